// File: rtl/ball_motion_sched.sv
// Pong ball timing scheduler: serve/rally/point/game-over sequencing, step
// pulse generation with per-hit speed-up, and score keeping.
module ball_motion_sched #(
  parameter int unsigned BASE_PERIOD  = 312500,
  parameter int unsigned SPEED_STEP   = 30000,
  parameter int unsigned MIN_PERIOD   = 62500,
  parameter int unsigned SERVE_CYCLES = 50000000,
  parameter int unsigned POINT_CYCLES = 25000000,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        paddle_hit,
  input  logic        miss_l,
  input  logic        miss_r,
  output logic        step,
  output logic [19:0] period,
  output logic [2:0]  state,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        serve_dir
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [19:0] BASE_P     = 20'(BASE_PERIOD);
  localparam logic [19:0] MIN_P      = 20'(MIN_PERIOD);
  localparam logic [19:0] STEP_P     = 20'(SPEED_STEP);
  localparam logic [20:0] HIT_THRESH = 21'(MIN_PERIOD + SPEED_STEP);
  localparam logic [25:0] SERVE_LAST = 26'(SERVE_CYCLES - 1);
  localparam logic [25:0] POINT_LAST = 26'(POINT_CYCLES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [19:0] period_q, period_d;
  logic        step_q, step_d;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic        serve_dir_q, serve_dir_d;
  logic        start_q, start_prev_q;
  logic        hit_q, hit_prev_q;

  logic        start_edge;
  logic        hit_edge;
  logic [25:0] wrap_at;

  assign start_edge = start_q & ~start_prev_q;
  assign hit_edge   = hit_q & ~hit_prev_q;
  // period is never below MIN_PERIOD, so period-1 cannot underflow
  assign wrap_at    = {6'b0, period_q} - 26'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    step_d      = 1'b0;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    serve_dir_d = serve_dir_q;
    if (!pause) begin
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            period_d = BASE_P;
            cnt_d    = '0;
            state_d  = S_SERVE;
          end
        end
        S_SERVE: begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_RALLY;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        S_RALLY: begin
          // a miss outranks a simultaneous paddle edge and suppresses the speed-up
          if (miss_l || miss_r) begin
            cnt_d   = '0;
            state_d = S_POINT;
            if (miss_r && !miss_l) begin
              if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
              serve_dir_d = 1'b1;
            end else if (miss_l && !miss_r) begin
              if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
              serve_dir_d = 1'b0;
            end
          end else begin
            if (hit_edge) begin
              if ({1'b0, period_q} >= HIT_THRESH) period_d = period_q - STEP_P;
              else                                period_d = MIN_P;
            end
            if (cnt_q >= wrap_at) begin
              cnt_d  = '0;
              step_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 26'd1;
            end
          end
        end
        S_POINT: begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (score_l_q == WIN || score_r_q == WIN) begin
              state_d = S_OVER;
            end else begin
              period_d = BASE_P;
              state_d  = S_SERVE;
            end
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        S_OVER: begin
          if (start_edge) begin
            score_l_d   = '0;
            score_r_d   = '0;
            serve_dir_d = 1'b0;
            period_d    = BASE_P;
            cnt_d       = '0;
            state_d     = S_SERVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      period_q     <= BASE_P;
      step_q       <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      serve_dir_q  <= 1'b0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      hit_q        <= 1'b0;
      hit_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      step_q       <= step_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      start_q      <= start;
      start_prev_q <= start_q;
      hit_q        <= paddle_hit;
      hit_prev_q   <= hit_q;
    end
  end

  assign step      = step_q;
  assign period    = period_q;
  assign state     = state_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve_dir = serve_dir_q;

endmodule

// File: tb/tb_ball_motion_sched.sv
// Scoreboard bench: stimulus queues expected output events (state changes,
// step pulses, snapshots) by cycle; a negedge monitor pops and compares them.
module tb_ball_motion_sched;

  logic        clk = 1'b0;
  logic        rst, start, pause, paddle_hit, miss_l, miss_r;
  logic        step, serve_dir;
  logic [19:0] period;
  logic [2:0]  state;
  logic [3:0]  score_l, score_r;

  ball_motion_sched #(
    .BASE_PERIOD (10),
    .SPEED_STEP  (3),
    .MIN_PERIOD  (4),
    .SERVE_CYCLES(5),
    .POINT_CYCLES(3),
    .WIN_SCORE   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .paddle_hit(paddle_hit),
    .miss_l    (miss_l),
    .miss_r    (miss_r),
    .step      (step),
    .period    (period),
    .state     (state),
    .score_l   (score_l),
    .score_r   (score_r),
    .serve_dir (serve_dir)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic [19:0] per;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        sd;
    logic        stp;
  } ev_t;

  ev_t  sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   c          = 0;
  logic snap       = 1'b0;
  logic mon_en     = 1'b0;

  task automatic exp_ev(input int k, input logic [2:0] st, input logic [19:0] per,
                        input logic [3:0] sl, input logic [3:0] sr, input logic sd,
                        input logic stp);
    ev_t e;
    e.cyc = c + k; e.st = st; e.per = per; e.sl = sl; e.sr = sr; e.sd = sd; e.stp = stp;
    sb.push_back(e);
  endtask

  task automatic goto(input int k);
    while (cyc < c + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: an event is a step pulse, a state change, or a snapshot request.
  initial begin : monitor
    logic [2:0] last_st;
    ev_t e;
    last_st = 3'd0;
    forever begin
      @(negedge clk);
      if (mon_en && (step === 1'b1 || snap || state !== last_st)) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event: got cyc=%0d st=%0d per=%0d step=%0b, required no event",
                   cyc, state, period, step);
        end else begin
          e = sb.pop_front();
          if (cyc != e.cyc || state !== e.st || period !== e.per || score_l !== e.sl ||
              score_r !== e.sr || serve_dir !== e.sd || step !== e.stp) begin
            mismatched++;
            $display("FAIL event: got cyc=%0d st=%0d per=%0d sl=%0d sr=%0d sd=%0b step=%0b, required cyc=%0d st=%0d per=%0d sl=%0d sr=%0d sd=%0b step=%0b",
                     cyc, state, period, score_l, score_r, serve_dir, step,
                     e.cyc, e.st, e.per, e.sl, e.sr, e.sd, e.stp);
          end
        end
      end
      last_st = state;
    end
  end

  initial begin : stimulus
    ev_t e;
    rst = 1'b1; start = 1'b0; pause = 1'b0; paddle_hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    goto(2);
    mon_en = 1'b1;
    goto(3);
    exp_ev(3, 3'd0, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    snap = 1'b1;
    goto(4);
    snap = 1'b0;
    rst  = 1'b0;
    goto(6);

    // Serve and first rally at base period
    c = cyc;
    start = 1'b1;
    exp_ev(2,  3'd1, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(7,  3'd2, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(17, 3'd2, 20'd10, 4'd0, 4'd0, 1'b0, 1'b1);
    exp_ev(27, 3'd2, 20'd10, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(1);  start = 1'b0;

    // Three paddle edges: 10 -> 7 -> 4 -> 4; first one held high for a while
    goto(28); paddle_hit = 1'b1;
    exp_ev(34, 3'd2, 20'd7, 4'd0, 4'd0, 1'b0, 1'b1);
    exp_ev(41, 3'd2, 20'd7, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(40); paddle_hit = 1'b0;
    goto(42); paddle_hit = 1'b1;
    exp_ev(45, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    exp_ev(49, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(46); paddle_hit = 1'b0;
    goto(48); paddle_hit = 1'b1;
    exp_ev(53, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(50); paddle_hit = 1'b0;

    // Pause for 20 cycles with a miss inside; steps resume shifted by 20
    goto(54); pause = 1'b1;
    exp_ev(65, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(77, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    exp_ev(81, 3'd2, 20'd4, 4'd0, 4'd0, 1'b0, 1'b1);
    goto(60); miss_r = 1'b1;
    goto(62); miss_r = 1'b0;
    goto(65); snap = 1'b1;
    goto(66); snap = 1'b0;
    goto(74); pause = 1'b0;

    // Right miss: point to left, reserve at base period
    goto(82); miss_r = 1'b1;
    exp_ev(83,  3'd3, 20'd4,  4'd1, 4'd0, 1'b1, 1'b0);
    exp_ev(86,  3'd1, 20'd10, 4'd1, 4'd0, 1'b1, 1'b0);
    exp_ev(91,  3'd2, 20'd10, 4'd1, 4'd0, 1'b1, 1'b0);
    exp_ev(101, 3'd2, 20'd10, 4'd1, 4'd0, 1'b1, 1'b1);
    goto(83); miss_r = 1'b0;
    goto(93); start = 1'b1;  // ignored in RALLY
    goto(94); start = 1'b0;

    // Second right miss reaches WIN_SCORE -> OVER
    goto(103); miss_r = 1'b1;
    exp_ev(104, 3'd3, 20'd10, 4'd2, 4'd0, 1'b1, 1'b0);
    exp_ev(107, 3'd4, 20'd10, 4'd2, 4'd0, 1'b1, 1'b0);
    goto(104); miss_r = 1'b0;

    // New game from OVER
    goto(110); start = 1'b1;
    exp_ev(112, 3'd1, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(117, 3'd2, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    goto(111); start = 1'b0;

    // Double miss: replay with no score change
    goto(120); miss_l = 1'b1; miss_r = 1'b1;
    exp_ev(121, 3'd3, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(124, 3'd1, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    exp_ev(129, 3'd2, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    goto(121); miss_l = 1'b0; miss_r = 1'b0;

    // Left miss coinciding with a paddle edge: period stays 10
    goto(130); paddle_hit = 1'b1;
    goto(131); miss_l = 1'b1;
    exp_ev(132, 3'd3, 20'd10, 4'd0, 4'd1, 1'b0, 1'b0);
    exp_ev(135, 3'd1, 20'd10, 4'd0, 4'd1, 1'b0, 1'b0);
    exp_ev(140, 3'd2, 20'd10, 4'd0, 4'd1, 1'b0, 1'b0);
    goto(132); miss_l = 1'b0; paddle_hit = 1'b0;

    // Reset in the middle of POINT
    goto(142); miss_r = 1'b1;
    exp_ev(143, 3'd3, 20'd10, 4'd1, 4'd1, 1'b1, 1'b0);
    goto(143); miss_r = 1'b0;
    goto(144); rst = 1'b1;
    exp_ev(145, 3'd0, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    goto(146); rst = 1'b0;
    goto(148);
    exp_ev(148, 3'd0, 20'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    snap = 1'b1;
    goto(149); snap = 1'b0;
    goto(160);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event: got none, required cyc=%0d st=%0d per=%0d step=%0b",
               e.cyc, e.st, e.per, e.stp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ball_motion_sched.md
BALL_MOTION_SCHED -- requirements
Module: ball_motion_sched

Interface
REQ-001 Parameter BASE_PERIOD, default 312500, is the rally start step period in clk cycles.
REQ-002 Parameter SPEED_STEP, default 30000, is the period decrement applied per paddle hit.
REQ-003 Parameter MIN_PERIOD, default 62500, is the floor on the step period.
REQ-004 Parameter SERVE_CYCLES, default 50000000, is the serve hold time in cycles.
REQ-005 Parameter POINT_CYCLES, default 25000000, is the post-point hold time in cycles.
REQ-006 Parameter WIN_SCORE, default 9, is the score that ends the game.
REQ-007 clk  in  1  system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  serve/new-game button, level; its rising edge is the event.
REQ-010 pause  in  1  level; freezes play while high.
REQ-011 paddle_hit  in  1  collision level; its rising edge is the event.
REQ-012 miss_l, miss_r  in  1 each  ball passed left/right edge, level.
REQ-013 step  out  1  one-cycle ball-advance pulse.
REQ-014 period  out  20  current step period in cycles.
REQ-015 state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4.
REQ-016 score_l, score_r  out  4 each  player scores.
REQ-017 serve_dir  out  1  0 = serve toward left, 1 = toward right.

Function
REQ-018 The block SHALL register start and paddle_hit once and detect rising edges as current=1 with previous=0; previous registers SHALL update every cycle, including while paused.
REQ-019 IDLE: step=0; a start edge SHALL load period=BASE_PERIOD, clear cycle counter, and enter SERVE next cycle.
REQ-020 SERVE: counter SHALL increment each unpaused cycle; when counter == SERVE_CYCLES-1 the FSM SHALL enter RALLY with counter cleared; step SHALL stay 0.
REQ-021 RALLY: counter SHALL increment each unpaused cycle and wrap to 0 when counter >= period-1; step SHALL be 1 in exactly the cycle after each wrap (registered on counter==0 transition), giving one pulse per period cycles.
REQ-022 RALLY paddle_hit edge: if period >= MIN_PERIOD + SPEED_STEP, period SHALL decrease by SPEED_STEP, else period SHALL load MIN_PERIOD; new period SHALL take effect on the next compare.
REQ-023 RALLY miss_r high (miss_l low): score_l SHALL increment, serve_dir SHALL become 1; enter POINT.
REQ-024 RALLY miss_l high (miss_r low): score_r SHALL increment, serve_dir SHALL become 0; enter POINT.
REQ-025 RALLY miss_l and miss_r high in the same cycle: no score change, serve_dir unchanged, enter POINT (replay).
REQ-026 A miss in the same cycle as a paddle_hit edge SHALL take priority; period SHALL NOT change.
REQ-027 POINT: counter SHALL count POINT_CYCLES unpaused cycles; then if score_l or score_r == WIN_SCORE enter OVER, else load period=BASE_PERIOD and enter SERVE.
REQ-028 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-029 OVER: step=0, scores held; a start edge SHALL clear both scores, set serve_dir=0, load BASE_PERIOD, enter SERVE.
REQ-030 start edges in SERVE, RALLY, POINT SHALL be ignored.
REQ-031 pause high SHALL freeze counter, period, scores and state, and force step=0; miss and paddle events during pause SHALL be ignored; resume SHALL continue from the frozen count.
REQ-032 Counter SHALL be 26 bits; all compares unsigned.

Reset
REQ-033 rst SHALL dominate all inputs in the same cycle: state=IDLE, counter=0, period=BASE_PERIOD, step=0, score_l=score_r=0, serve_dir=0, edge registers=0.
REQ-034 rst asserted mid-RALLY or mid-POINT SHALL abandon the rally with no score change beyond reset values.

Verification (bench overrides: BASE_PERIOD=10, SPEED_STEP=3, MIN_PERIOD=4, SERVE_CYCLES=5, POINT_CYCLES=3, WIN_SCORE=2)
REQ-035 rst then start pulse -> state 1 for 5 cycles, then state 2; step pulses every 10 cycles.
REQ-036 Three paddle_hit edges in RALLY -> period 10->7->4->4; step spacing follows; held-high paddle_hit gives one decrement only.
REQ-037 miss_r in RALLY -> score_l=1, serve_dir=1, state 3 for 3 cycles, then state 1 with period=10; second miss_r -> score_l=2, state 4; start -> scores 0, state 1.
REQ-038 miss_l and miss_r same cycle -> scores unchanged, state 3; miss with simultaneous paddle edge -> period unchanged.
REQ-039 pause held 20 cycles mid-RALLY -> no step, counter frozen, misses ignored; after release next step arrives after remaining count.
REQ-040 rst asserted mid-POINT -> next cycle all outputs at REQ-033 values.
